// File: rtl/ldpc_pkg.sv
// Shared widths and the 4-bit sign-magnitude message encoding used by the loader, VN and CN stages.
package ldpc_pkg;

  localparam int LLR_IN_W = 8;
  localparam int MSG_W    = 4;
  localparam int MAG_W    = 2;
  localparam int SIGN_BIT = 2;

  typedef logic [MSG_W-1:0] msg_t;
  typedef logic [MAG_W-1:0] mag_t;

  // A zero magnitude always encodes as +0 so downstream min/sign logic never sees -0.
  function automatic msg_t sm_encode(input logic sign, input mag_t mag);
    msg_t m;
    m           = '0;
    m[MAG_W-1:0] = mag;
    m[SIGN_BIT] = sign && (mag != '0);
    return m;
  endfunction

endpackage

// File: rtl/llr_frame_loader_if.sv
// LLR stream in / frame out handshake bundle; master is the upstream+consumer side, slave is the loader.
interface llr_frame_loader_if
  import ldpc_pkg::*;
#(
  parameter int NUM_VN = 8
);

  logic                    in_valid;
  logic                    in_ready;
  logic [LLR_IN_W-1:0]     in_llr;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [MSG_W*NUM_VN-1:0] out_frame;
  logic                    out_short;
  logic                    out_err;

  modport master (
    output in_valid, in_llr, in_last, out_ready,
    input  in_ready, out_valid, out_frame, out_short, out_err
  );

  modport slave (
    input  in_valid, in_llr, in_last, out_ready,
    output in_ready, out_valid, out_frame, out_short, out_err
  );

endinterface

// File: rtl/llr_quant.sv
// Combinational 8-bit two's-complement LLR to 4-bit sign-magnitude quantiser: |x| >> SHIFT, saturated to 3.
module llr_quant
  import ldpc_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic [LLR_IN_W-1:0] llr,
  output msg_t                q
);

  logic [LLR_IN_W:0] ext;
  logic [LLR_IN_W:0] mag_full;
  logic [LLR_IN_W:0] mag_shr;
  mag_t              mag;

  // One extra bit so that -128 produces +128 instead of wrapping back to -128.
  always_comb begin
    ext      = {llr[LLR_IN_W-1], llr};
    mag_full = llr[LLR_IN_W-1] ? ((LLR_IN_W+1)'(0) - ext) : ext;
    mag_shr  = mag_full >> SHIFT;
    mag      = (mag_shr[LLR_IN_W:MAG_W] != '0) ? '1 : mag_shr[MAG_W-1:0];
    q        = sm_encode(llr[LLR_IN_W-1], mag);
  end

endmodule

// File: rtl/llr_frame_loader.sv
// Quantises a serial LLR stream into NUM_VN-slot frames held in two ping-pong banks; frame valid 1 cycle after closing LLR.
// in_ready is registered and drops only when both banks hold unconsumed frames.
module llr_frame_loader
  import ldpc_pkg::*;
#(
  parameter int NUM_VN = 8,
  parameter int SHIFT  = 4,
  parameter int CNT_W  = $clog2(NUM_VN)
) (
  input logic               clk,
  input logic               rst,
  llr_frame_loader_if.slave bus
);

  localparam int              FRAME_W   = MSG_W * NUM_VN;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_VN - 1);

  logic [FRAME_W-1:0] bank [2];
  logic [1:0]         full;
  logic [1:0]         short_flag;
  logic               wr_bank;
  logic               rd_bank;
  logic [CNT_W-1:0]   cnt;
  logic               ready_q;
  logic               err_q;

  msg_t       q;
  logic       take;
  logic       give;
  logic       at_end;
  logic       close;
  logic       early;
  logic [1:0] full_nxt;
  logic       wr_nxt;

  llr_quant #(.SHIFT(SHIFT)) u_quant (
    .llr (bus.in_llr),
    .q   (q)
  );

  assign take   = bus.in_valid && ready_q;
  assign give   = full[rd_bank] && bus.out_ready;
  assign at_end = (cnt == LAST_SLOT);
  assign close  = take && (at_end || bus.in_last);
  assign early  = take && bus.in_last && !at_end;

  // A close always targets a non-full bank, so it can never collide with a consume on the same bank.
  always_comb begin
    full_nxt = full;
    if (give) full_nxt[rd_bank] = 1'b0;
    if (close) full_nxt[wr_bank] = 1'b1;
    wr_nxt = close ? !wr_bank : wr_bank;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank[0]    <= '0;
      bank[1]    <= '0;
      full       <= '0;
      short_flag <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      cnt        <= '0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      full    <= full_nxt;
      wr_bank <= wr_nxt;
      ready_q <= !full_nxt[wr_nxt];
      err_q   <= take && at_end && !bus.in_last;

      if (give) begin
        short_flag[rd_bank] <= 1'b0;
        rd_bank             <= !rd_bank;
      end

      if (take) begin
        for (int i = 0; i < NUM_VN; i++) begin
          if (CNT_W'(i) == cnt) begin
            bank[wr_bank][MSG_W*i +: MSG_W] <= q;
          end else if (early && (CNT_W'(i) > cnt)) begin
            bank[wr_bank][MSG_W*i +: MSG_W] <= '0;
          end
        end
        cnt <= close ? '0 : cnt + CNT_W'(1);
        if (early) short_flag[wr_bank] <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = full[rd_bank];
  assign bus.out_frame = bank[rd_bank];
  assign bus.out_short = short_flag[rd_bank];
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_llr_frame_loader.sv
// Bench for llr_frame_loader: directed scenarios plus a randomized stream against a frame-level reference model.
module tb_llr_frame_loader;

  localparam int NV    = 8;
  localparam int SHIFT = 4;
  localparam int FW    = 4 * NV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  llr_frame_loader_if #(.NUM_VN(NV)) bus ();

  llr_frame_loader #(.NUM_VN(NV), .SHIFT(SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference quantiser from the arithmetic definition: |v| / 2^SHIFT, clip at 3, no negative zero.
  function automatic logic [3:0] ref_q(input logic [7:0] v);
    int s;
    int mag;
    s   = int'($signed(v));
    mag = (s < 0 ? -s : s) / (1 << SHIFT);
    if (mag > 3) mag = 3;
    return {1'b0, (s < 0) && (mag != 0), 2'(mag)};
  endfunction

  // Caller is at a negedge; returns at the negedge after the LLR was accepted.
  task automatic push(input logic [7:0] v, input bit last);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_llr   = v;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      failures++;
      $display("FAIL push_timeout in_ready stayed %b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_frame !== '0) begin failures++; $display("FAIL rst_out_frame got=%h exp=0", bus.out_frame); end
    checks++; if (bus.out_short !== 1'b0) begin failures++; $display("FAIL rst_out_short got=%b exp=0", bus.out_short); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL rst_out_err got=%b exp=0", bus.out_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_quant_sweep();
    logic [7:0] vals [NV];
    vals = '{8'd0, 8'd15, 8'd16, 8'd47, 8'd48, 8'd127, 8'hFF, 8'hF0};
    bus.out_ready = 1'b0;
    for (int i = 0; i < NV; i++) push(vals[i], i == NV - 1);
    checks++; if (bus.out_frame !== 32'h5033_2100) begin failures++; $display("FAIL quant_frame got=%h exp=50332100", bus.out_frame); end
    push(8'h80, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_frame !== 32'h0000_0007) begin failures++; $display("FAIL quant_neg128 got=%h exp=00000007", bus.out_frame); end
    checks++; if (bus.out_short !== 1'b1) begin failures++; $display("FAIL quant_short got=%b exp=1", bus.out_short); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL quant_drained got=%b exp=0", bus.out_valid); end
  endtask

  // 16*8 does not fit a signed byte, so the 8th LLR uses 127 (same saturated slot value).
  task automatic test_full_frame();
    bus.out_ready = 1'b1;
    for (int i = 1; i < NV; i++) push(8'(16 * i), 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid got=%b exp=0", bus.out_valid); end
    push(8'd127, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL full_valid_latency got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_frame !== 32'h3333_3321) begin failures++; $display("FAIL full_frame got=%h exp=33333321", bus.out_frame); end
    checks++; if (bus.out_short !== 1'b0 || bus.out_err !== 1'b0) begin failures++; $display("FAIL full_flags short=%b err=%b exp 0 0", bus.out_short, bus.out_err); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL full_consumed got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]    v   [3][NV];
    logic [FW-1:0] exp [3];
    int            got;
    int            guard;
    for (int f = 0; f < 3; f++) begin
      exp[f] = '0;
      for (int i = 0; i < NV; i++) begin
        v[f][i] = 8'($urandom);
        exp[f][4*i +: 4] = ref_q(v[f][i]);
      end
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2 * NV; k++) begin
      if (k == 2 * NV - 1) begin
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_before16 got=%b exp=1", bus.in_ready); end
      end
      push(v[k / NV][k % NV], (k % NV) == NV - 1);
    end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_after16 got=%b exp=0", bus.in_ready); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_frame !== exp[0]) begin failures++; $display("FAIL bp_hold valid=%b frame=%h exp 1 %h", bus.out_valid, bus.out_frame, exp[0]); end
      @(negedge clk);
    end
    got = 0;
    fork
      begin
        for (int i = 0; i < NV; i++) push(v[2][i], i == NV - 1);
      end
      begin
        guard = 0;
        bus.out_ready = 1'b1;
        while (got < 3 && guard < 500) begin
          if (bus.out_valid === 1'b1) begin
            checks++; if (bus.out_frame !== exp[got]) begin failures++; $display("FAIL bp_order frame%0d got=%h exp=%h", got, bus.out_frame, exp[got]); end
            got++;
            if (got == 1) begin
              @(negedge clk);
              guard++;
              checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_return got=%b exp=1", bus.in_ready); end
              continue;
            end
          end
          @(negedge clk);
          guard++;
        end
        if (got < 3) begin checks++; failures++; $display("FAIL bp_timeout got=%0d frames exp=3", got); end
      end
    join
    bus.out_ready = 1'b0;
  endtask

  task automatic test_short_frame();
    logic [7:0]    v [NV];
    logic [FW-1:0] exp;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'd48, i == 2);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL short_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_frame !== 32'h0000_0333) begin failures++; $display("FAIL short_frame got=%h exp=00000333", bus.out_frame); end
    checks++; if (bus.out_short !== 1'b1) begin failures++; $display("FAIL short_flag got=%b exp=1", bus.out_short); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL short_consumed got=%b exp=0", bus.out_valid); end
    exp = '0;
    for (int i = 0; i < NV; i++) begin
      v[i] = 8'($urandom);
      exp[4*i +: 4] = ref_q(v[i]);
    end
    for (int i = 0; i < NV; i++) push(v[i], i == NV - 1);
    checks++; if (bus.out_frame !== exp || bus.out_short !== 1'b0) begin failures++; $display("FAIL short_next frame=%h short=%b exp %h 0", bus.out_frame, bus.out_short, exp); end
    @(negedge clk);
  endtask

  task automatic test_missing_last();
    logic [7:0]    v [NV];
    logic [FW-1:0] exp;
    int            early_err;
    early_err = 0;
    exp = '0;
    for (int i = 0; i < NV; i++) begin
      v[i] = 8'($urandom);
      exp[4*i +: 4] = ref_q(v[i]);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (bus.out_err !== 1'b0) early_err++;
      push(v[i], 1'b0);
    end
    checks++; if (early_err != 0) begin failures++; $display("FAIL err_early pulses=%0d exp=0", early_err); end
    checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", bus.out_err); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_frame !== exp || bus.out_short !== 1'b0) begin failures++; $display("FAIL err_frame valid=%b frame=%h short=%b exp 1 %h 0", bus.out_valid, bus.out_frame, bus.out_short, exp); end
    @(negedge clk);
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL err_width got=%b exp=0", bus.out_err); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0]    v [NV];
    logic [FW-1:0] exp;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NV; i++) push(8'($urandom), i == NV - 1);
    for (int i = 0; i < 5; i++) push(8'($urandom_range(16, 127)), 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_frame !== '0) begin failures++; $display("FAIL rstmid_outputs valid=%b frame=%h exp 0 0", bus.out_valid, bus.out_frame); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_release ready=%b valid=%b exp 1 0", bus.in_ready, bus.out_valid); end
    exp = '0;
    for (int i = 0; i < NV; i++) begin
      v[i] = 8'($urandom);
      exp[4*i +: 4] = ref_q(v[i]);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) push(v[i], i == NV - 1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_frame !== exp) begin failures++; $display("FAIL rstmid_fresh valid=%b frame=%h exp 1 %h", bus.out_valid, bus.out_frame, exp); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_residue got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [FW-1:0] expq [$];
    bit            exps [$];
    int            nframes;
    int            got;
    nframes = 30;
    got     = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int f = 0; f < nframes; f++) begin
          int            n;
          logic [7:0]    v [NV];
          logic [FW-1:0] fr;
          n  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NV) : NV;
          fr = '0;
          for (int i = 0; i < n; i++) begin
            v[i] = 8'($urandom);
            fr[4*i +: 4] = ref_q(v[i]);
          end
          expq.push_back(fr);
          exps.push_back(n < NV);
          for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            push(v[i], i == n - 1);
          end
        end
      end
      begin
        int guard;
        guard = 0;
        while (got < nframes && guard < 5000) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          if (bus.out_valid === 1'b1 && bus.out_ready) begin
            checks++;
            if (expq.size() == 0) begin
              failures++;
              $display("FAIL rand_unexpected frame=%h with no frame outstanding", bus.out_frame);
            end else if (bus.out_frame !== expq[0] || bus.out_short !== exps[0]) begin
              failures++;
              $display("FAIL rand_frame%0d got=%h short=%b exp=%h short=%b", got, bus.out_frame, bus.out_short, expq[0], exps[0]);
            end
            if (expq.size() != 0) begin
              void'(expq.pop_front());
              void'(exps.pop_front());
            end
            got++;
          end
          @(negedge clk);
          guard++;
        end
        if (got < nframes) begin checks++; failures++; $display("FAIL rand_timeout got=%0d frames exp=%0d", got, nframes); end
      end
    join
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_llr    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_quant_sweep();
    test_full_frame();
    test_back_to_back();
    test_short_frame();
    test_missing_last();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
